latent_seed_source: RTL and testbench

Latent-vector producer that sits directly upstream of the generator pipeline's seed FIFO. On request, it synthesises one 64-entry Q8.8 latent vector from an on-chip LFSR. Each sample is an approximate Gaussian, formed as the CLT sum of four bytes. The block streams the vector into the seed FIFO under `seed_full` backpressure, pulses the pipeline's `start` until the pipeline accepts it, then reports completion when the pipeline's `done` returns.

---
 rtl/latent_seed_source.sv | 125 ++++++++++++
 tb/tb_latent_seed_source.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/latent_seed_source.sv
// Latent-vector producer: fills the generator seed FIFO with SEED_COUNT approximate-Gaussian
// Q8.8 samples drawn from a Galois LFSR, then kicks the generator and waits for it to finish.
module latent_seed_source #(
    parameter int          SEED_COUNT = 64,
    parameter int          DATA_WIDTH = 16,
    parameter logic [31:0] LFSR_INIT  = 32'hACE12B7F
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  reseed_en,
    input  logic [31:0]           reseed_value,
    input  logic                  seed_full,
    input  logic [6:0]            seed_level,
    output logic                  seed_wr_en,
    output logic [DATA_WIDTH-1:0] seed_wr_data,
    output logic                  gen_start,
    input  logic                  gen_busy,
    input  logic                  gen_done,
    output logic                  busy,
    output logic                  done,
    output logic [15:0]           vec_count
);

    localparam logic [31:0]     LFSR_TAPS  = 32'h80200003;
    localparam int              IDX_W      = $clog2(SEED_COUNT);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(SEED_COUNT - 1);
    localparam logic [6:0]      LEVEL_FULL = 7'(SEED_COUNT);

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        WAIT_LEVEL,
        KICK,
        WAIT_ACK,
        WAIT_DONE
    } state_t;

    state_t           state;
    logic [31:0]      lfsr;
    logic [31:0]      lfsr_next;
    logic [IDX_W-1:0] idx;
    logic [1:0]       retry;
    logic [9:0]       byte_sum;
    logic [11:0]      centered;
    logic [DATA_WIDTH-1:0] sample;

    // Sample is derived from the current LFSR state; the state only steps when a sample is written.
    always_comb begin
        lfsr_next = {1'b0, lfsr[31:1]} ^ (lfsr[0] ? LFSR_TAPS : 32'h0);
        byte_sum  = 10'(lfsr[7:0]) + 10'(lfsr[15:8]) + 10'(lfsr[23:16]) + 10'(lfsr[31:24]);
        centered  = 12'(byte_sum) - 12'd510;
        sample    = {{(DATA_WIDTH-13){centered[11]}}, centered, 1'b0};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            lfsr         <= LFSR_INIT;
            idx          <= '0;
            retry        <= '0;
            seed_wr_en   <= 1'b0;
            seed_wr_data <= '0;
            gen_start    <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            vec_count    <= '0;
        end else begin
            // NOTE: pulse outputs default low here so every state only has to name the cycle it fires.
            seed_wr_en <= 1'b0;
            gen_start  <= 1'b0;
            done       <= 1'b0;
            case (state)
                IDLE: begin
                    if (reseed_en) begin
                        lfsr <= (reseed_value == 32'h0) ? LFSR_INIT : reseed_value;
                    end else if (start && seed_level == 7'd0) begin
                        idx   <= '0;
                        busy  <= 1'b1;
                        state <= FILL;
                    end
                end
                FILL: begin
                    if (!seed_full) begin
                        seed_wr_en   <= 1'b1;
                        seed_wr_data <= sample;
                        lfsr         <= lfsr_next;
                        idx          <= idx + 1'b1;
                        if (idx == LAST_IDX) state <= WAIT_LEVEL;
                    end
                end
                // The FIFO level lags our writes; wait until it reports the whole vector.
                WAIT_LEVEL: begin
                    if (seed_level >= LEVEL_FULL) state <= KICK;
                end
                KICK: begin
                    gen_start <= 1'b1;
                    retry     <= '0;
                    state     <= WAIT_ACK;
                end
                WAIT_ACK: begin
                    if (gen_busy) begin
                        state <= WAIT_DONE;
                    end else begin
                        retry <= retry + 2'd1;
                        if (retry == 2'd3) state <= KICK;
                    end
                end
                WAIT_DONE: begin
                    if (gen_done) begin
                        done      <= 1'b1;
                        vec_count <= vec_count + 16'd1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_latent_seed_source.sv
// Directed bench for latent_seed_source: hand-computed first samples, an LFSR reference model,
// FIFO backpressure, start retries, input blocking outside IDLE and mid-vector reset.
module tb_latent_seed_source;

    localparam logic [31:0] LFSR_INIT = 32'hACE12B7F;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        reseed_en = 1'b0;
    logic [31:0] reseed_value = 32'h0;
    logic        seed_full = 1'b0;
    logic [6:0]  seed_level = 7'd0;
    logic        seed_wr_en;
    logic [15:0] seed_wr_data;
    logic        gen_start;
    logic        gen_busy = 1'b0;
    logic        gen_done = 1'b0;
    logic        busy;
    logic        done;
    logic [15:0] vec_count;

    int   vectors = 0;
    int   miscompares = 0;
    int   exp_vec = 0;
    logic full_prev = 1'b0;

    latent_seed_source #(
        .SEED_COUNT(64),
        .DATA_WIDTH(16),
        .LFSR_INIT (LFSR_INIT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .reseed_en   (reseed_en),
        .reseed_value(reseed_value),
        .seed_full   (seed_full),
        .seed_level  (seed_level),
        .seed_wr_en  (seed_wr_en),
        .seed_wr_data(seed_wr_data),
        .gen_start   (gen_start),
        .gen_busy    (gen_busy),
        .gen_done    (gen_done),
        .busy        (busy),
        .done        (done),
        .vec_count   (vec_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Remembers the seed_full value the DUT sees at the coming edge, then samples 1 time unit later.
    task automatic tick();
        full_prev = seed_full;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? 32'h80200003 : 32'h0);
    endfunction

    function automatic logic [15:0] sample_of(input logic [31:0] s);
        int sum;
        sum = int'(s[7:0]) + int'(s[15:8]) + int'(s[23:16]) + int'(s[31:24]);
        return 16'((sum - 510) * 2);
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_wr_en"}, 32'(seed_wr_en), 32'd0);
        check({tag, "_wr_data"}, 32'(seed_wr_data), 32'd0);
        check({tag, "_gen_start"}, 32'(gen_start), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_vec_count"}, 32'(vec_count), 32'd0);
    endtask

    task automatic do_reseed(input logic [31:0] value);
        reseed_en    = 1'b1;
        reseed_value = value;
        tick();
        reseed_en    = 1'b0;
        check("reseed_busy", 32'(busy), 32'd0);
    endtask

    // Starts a vector and consumes its writes, checking every sample against the model.
    task automatic run_fill(input logic [31:0] seed, input bit rand_bp, input bit poke,
                            input int abort_at, output logic [31:0] end_state,
                            output logic [15:0] first_data, output logic [15:0] second_data,
                            output bit aborted);
        logic [31:0] m;
        int writes, c, first_c, last_c, extra;
        bit full_viol;
        m = seed; writes = 0; first_c = -1; last_c = -1; extra = 0; full_viol = 0;
        aborted = 0; first_data = '0; second_data = '0;
        seed_level = 7'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        c = 1;
        check("busy_rise", 32'(busy), 32'd1);
        while (writes < 64 && c < 400) begin
            seed_full = rand_bp ? 1'($urandom_range(0, 1)) : 1'b0;
            if (poke && (c == 20 || c == 21)) begin
                start = 1'b1; reseed_en = 1'b1; reseed_value = 32'h12345678;
            end else begin
                start = 1'b0; reseed_en = 1'b0;
            end
            tick();
            c++;
            if (seed_wr_en) begin
                if (full_prev) full_viol = 1;
                check("sample", 32'(seed_wr_data), 32'(sample_of(m)));
                if (writes == 0) first_data = seed_wr_data;
                if (writes == 1) second_data = seed_wr_data;
                m = lfsr_step(m);
                if (first_c < 0) first_c = c;
                last_c = c;
                writes++;
                if (writes == abort_at) begin
                    rst = 1'b1;
                    #1;
                    check_reset_outputs("abort");
                    tick();
                    tick();
                    rst = 1'b0;
                    seed_full = 1'b0;
                    start = 1'b0; reseed_en = 1'b0;
                    aborted = 1;
                    end_state = LFSR_INIT;
                    return;
                end
            end
        end
        seed_full = 1'b0; start = 1'b0; reseed_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (seed_wr_en) extra++;
        end
        check("write_count", 32'(writes + extra), 32'd64);
        check("write_while_full", 32'(full_viol), 32'd0);
        if (!rand_bp) begin
            check("first_write_cycle", 32'(first_c), 32'd2);
            check("last_write_cycle", 32'(last_c), 32'd65);
        end
        end_state = m;
    endtask

    // Raises the FIFO level, waits for the kick, optionally withholds gen_busy to force retries.
    task automatic run_kick(input bit retry_test);
        bit seen, stray;
        seen = 0; stray = 0;
        seed_level = 7'd64;
        gen_busy   = 1'b0;
        for (int b = 0; b < 20 && !seen; b++) begin
            tick();
            if (gen_start) seen = 1;
        end
        check("kick_seen", 32'(seen), 32'd1);
        if (retry_test) begin
            for (int t = 1; t <= 12; t++) begin
                tick();
                check("kick_pulse", 32'(gen_start), 32'((t == 5) || (t == 10)));
            end
        end
        gen_busy   = 1'b1;
        seed_level = 7'd0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (gen_start || done) stray = 1;
        end
        check("no_kick_after_ack", 32'(stray), 32'd0);
        check("busy_in_wait_done", 32'(busy), 32'd1);
        gen_done = 1'b1;
        tick();
        gen_done = 1'b0;
        gen_busy = 1'b0;
        exp_vec++;
        check("done_pulse", 32'(done), 32'd1);
        check("vec_count", 32'(vec_count), 32'(exp_vec));
        check("busy_fall", 32'(busy), 32'd0);
        tick();
        check("done_single", 32'(done), 32'd0);
    endtask

    initial begin
        logic [31:0] st;
        logic [15:0] f0, f1;
        bit ab, activity;

        #1;
        check_reset_outputs("reset");
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Plain run from the reset seed, with three kicks before the pipeline accepts.
        run_fill(LFSR_INIT, 0, 0, -1, st, f0, f1, ab);
        check("first_sample_init", 32'(f0), 32'h0072);
        check("second_sample_init", 32'(f1), 32'h00F2);
        run_kick(1);

        // Non-empty FIFO: start must be ignored.
        activity = 0;
        seed_level = 7'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (busy || seed_wr_en) activity = 1;
        end
        check("level_nonzero_ignored", 32'(activity), 32'd0);
        seed_level = 7'd0;

        // Continue the sequence; start/reseed pulses mid-fill must not disturb it.
        run_fill(st, 0, 1, -1, st, f0, f1, ab);
        run_kick(0);

        do_reseed(32'hFFFFFFFF);
        run_fill(32'hFFFFFFFF, 1, 0, -1, st, f0, f1, ab);
        check("first_sample_ones", 32'(f0), 32'h03FC);
        run_kick(0);

        do_reseed(32'h01010101);
        run_fill(32'h01010101, 0, 0, -1, st, f0, f1, ab);
        check("first_sample_0101", 32'(f0), 32'hFC0C);
        run_kick(0);

        do_reseed(32'h0);
        run_fill(LFSR_INIT, 1, 0, -1, st, f0, f1, ab);
        check("first_sample_zero_reseed", 32'(f0), 32'h0072);
        check("second_sample_zero_reseed", 32'(f1), 32'h00F2);
        run_kick(0);

        // Reset after the 30th write, then restart from the reset seed.
        run_fill(st, 0, 0, 30, st, f0, f1, ab);
        check("abort_taken", 32'(ab), 32'd1);
        exp_vec = 0;
        tick();
        run_fill(LFSR_INIT, 0, 0, -1, st, f0, f1, ab);
        check("first_sample_after_rst", 32'(f0), 32'h0072);
        run_kick(0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
